// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce.
// Optional build macro KEYPAD_MULTI_REJECT_EN: multi-key frames read as no key.
module keypad_scanner #(
    parameter int SCAN_DIV       = 2000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key,
    output logic        key_change,
    output logic        any_key
);

    typedef enum logic {SCAN, EVAL} state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB       = 4'(DEBOUNCE_SCANS);

    state_t      state, state_next;
    logic [3:0]  row_s1, row_s2;
    logic [15:0] div, div_next;
    logic [1:0]  column, column_next;
    logic [15:0] frame, frame_next;
    logic [15:0] prev, prev_next;
    logic [15:0] cand, key_next;
    logic [3:0]  stable, stable_next;
    logic        change_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SCAN;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div        <= '0;
            column     <= '0;
            frame      <= 16'hFFFF;
            prev       <= 16'hFFFF;
            stable     <= '0;
            key        <= 16'hFFFF;
            key_change <= 1'b0;
            any_key    <= 1'b0;
        end else begin
            div        <= div_next;
            column     <= column_next;
            frame      <= frame_next;
            prev       <= prev_next;
            stable     <= stable_next;
            key        <= key_next;
            key_change <= change_next;
            any_key    <= ~&key_next;
        end
    end

    always_comb begin
        state_next  = state;
        div_next    = div;
        column_next = column;
        frame_next  = frame;
        prev_next   = prev;
        stable_next = stable;
        key_next    = key;
        change_next = 1'b0;
        col_out     = 4'b1111;
        cand        = frame;
`ifdef KEYPAD_MULTI_REJECT_EN
        // More than one zero bit: clear lowest zero and see if any remain
        if (((~frame) & ((~frame) - 16'd1)) != 16'd0)
            cand = 16'hFFFF;
`endif
        unique case (state)
            SCAN: begin
                col_out = ~(4'b0001 << column);
                if (div == DIV_LAST) begin
                    div_next = '0;
                    for (int r = 0; r < 4; r++)
                        frame_next[{r[1:0], column}] = row_s2[r];
                    if (column == 2'd3) begin
                        column_next = 2'd0;
                        state_next  = EVAL;
                    end else begin
                        column_next = column + 2'd1;
                    end
                end else begin
                    div_next = div + 16'd1;
                end
            end
            EVAL: begin
                if (cand == prev)
                    stable_next = (stable >= DB) ? DB : stable + 4'd1;
                else
                    stable_next = 4'd1;
                prev_next = cand;
                if (stable_next >= DB && cand != key) begin
                    key_next    = cand;
                    change_next = 1'b1;
                end
                state_next = SCAN;
            end
        endcase
    end

endmodule
